branch_predict_ctrl: RTL and testbench

//  Branch-direction predictor and misprediction-recovery sequencer for the 5-stage pipeline.
//  - IF side: a table of 2-bit saturating counters (PHT) indexed by PC gives a taken/not-taken prediction.
//  - MEM side: resolves each branch, trains the PHT, and on a mispredict redirects the PC and flushes IF/ID/EX.
//  - Masks resolutions while the squashed bubbles drain.

---
 rtl/branch_predict_ctrl_if.sv | 36 +++
 rtl/branch_predict_ctrl.sv | 108 ++++++++++
 tb/tb_branch_predict_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_ctrl_if.sv
// Pipeline-side signal bundle for branch_predict_ctrl: IF prediction request/response,
// MEM resolution, and the redirect/flush/statistics outputs.
interface branch_predict_ctrl_if;
  logic [31:0] IF_PC;
  logic        IF_Is_Branch;
  logic [31:0] IF_Target;
  logic        Pred_Taken;
  logic [31:0] Pred_Next_PC;
  logic        MEM_Valid_Branch;
  logic [31:0] MEM_PC;
  logic        MEM_Taken;
  logic [31:0] MEM_Target;
  logic        MEM_Pred_Taken;
  logic        D_Bubble;
  logic        PC_Redirect;
  logic [31:0] Redirect_PC;
  logic        Flush_IF;
  logic        Flush_ID;
  logic        Flush_EX;
  logic [15:0] Branch_Count;
  logic [15:0] Mispredict_Count;

  modport master (
    output IF_PC, IF_Is_Branch, IF_Target,
    output MEM_Valid_Branch, MEM_PC, MEM_Taken, MEM_Target, MEM_Pred_Taken, D_Bubble,
    input  Pred_Taken, Pred_Next_PC, PC_Redirect, Redirect_PC,
    input  Flush_IF, Flush_ID, Flush_EX, Branch_Count, Mispredict_Count
  );

  modport slave (
    input  IF_PC, IF_Is_Branch, IF_Target,
    input  MEM_Valid_Branch, MEM_PC, MEM_Taken, MEM_Target, MEM_Pred_Taken, D_Bubble,
    output Pred_Taken, Pred_Next_PC, PC_Redirect, Redirect_PC,
    output Flush_IF, Flush_ID, Flush_EX, Branch_Count, Mispredict_Count
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit-counter branch predictor with mispredict redirect/flush and a recovery mask.
// Optional resolution/mispredict statistics counters are enabled by defining BP_STATS_EN.
module branch_predict_ctrl #(
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned RECOVER_N = 3
) (
  input logic                  Clk,
  input logic                  reset,
  branch_predict_ctrl_if.slave bp
);
  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t           state;
  logic [2:0]       rc;
  logic [1:0]       pht [DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             mis;
  logic             upd;

  assign if_idx  = bp.IF_PC[IDX_W+1:2];
  assign mem_idx = bp.MEM_PC[IDX_W+1:2];

  // Gated by reset so redirect/flush stay low for the whole time reset is held.
  assign mis = reset & (state == IDLE) & bp.MEM_Valid_Branch
             & (bp.MEM_Taken != bp.MEM_Pred_Taken);
  assign upd = (state == IDLE) & bp.MEM_Valid_Branch & ~bp.D_Bubble;

  always_comb begin
    bp.Pred_Taken   = bp.IF_Is_Branch & pht[if_idx][1];
    bp.Pred_Next_PC = bp.Pred_Taken ? bp.IF_Target : bp.IF_PC + 32'd4;
    bp.PC_Redirect  = mis;
    bp.Flush_IF     = mis;
    bp.Flush_ID     = mis;
    bp.Flush_EX     = mis;
    bp.Redirect_PC  = '0;
    if (mis)
      bp.Redirect_PC = bp.MEM_Taken ? bp.MEM_Target : bp.MEM_PC + 32'd4;
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mis) begin
            state <= RECOVER;
            rc    <= 3'(RECOVER_N);
          end
        end
        RECOVER: begin
          if (!bp.D_Bubble) begin
            rc <= rc - 3'd1;
            if (rc == 3'd1)
              state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          rc    <= '0;
        end
      endcase
    end
  end

  // Read-before-write: IF sees the old entry on a same-index update cycle.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        pht[i] <= 2'b01;
    end else if (upd) begin
      if (bp.MEM_Taken) begin
        if (pht[mem_idx] != 2'b11)
          pht[mem_idx] <= pht[mem_idx] + 2'b01;
      end else begin
        if (pht[mem_idx] != 2'b00)
          pht[mem_idx] <= pht[mem_idx] - 2'b01;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (upd && branch_cnt != '1)
        branch_cnt <= branch_cnt + 16'd1;
      if (mis && mispredict_cnt != '1)
        mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

  assign bp.Branch_Count     = branch_cnt;
  assign bp.Mispredict_Count = mispredict_cnt;
`else
  assign bp.Branch_Count     = '0;
  assign bp.Mispredict_Count = '0;
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed vectors with literal expectations, plus a
// behavioural predictor model compared against every output on every falling clock edge.
module tb_branch_predict_ctrl;
`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int RN = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  branch_predict_ctrl_if bif ();

  branch_predict_ctrl #(.IDX_W(4), .RECOVER_N(3)) dut (
    .Clk   (clk),
    .reset (rst_n),
    .bp    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int pht_m [16];
  int rec_left;   // cycles of masking still owed; 0 means resolutions are live
  int bc_m;
  int mc_m;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit model_mis();
    return rst_n && rec_left == 0 && bif.MEM_Valid_Branch
           && (bif.MEM_Taken != bif.MEM_Pred_Taken);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) pht_m[i] = 1;
      rec_left = 0;
      bc_m     = 0;
      mc_m     = 0;
    end else if (rec_left == 0) begin
      bit m;
      m = model_mis();
      if (bif.MEM_Valid_Branch && !bif.D_Bubble) begin
        int k;
        k = idx_of(bif.MEM_PC);
        if (bif.MEM_Taken) pht_m[k] = (pht_m[k] == 3) ? 3 : pht_m[k] + 1;
        else               pht_m[k] = (pht_m[k] == 0) ? 0 : pht_m[k] - 1;
        if (bc_m < 65535) bc_m++;
      end
      if (m) begin
        rec_left = RN;
        if (mc_m < 65535) mc_m++;
      end
    end else if (!bif.D_Bubble) begin
      rec_left--;
    end
  end

  always @(negedge clk) begin
    bit          m;
    bit          pt;
    logic [31:0] npc;
    logic [31:0] rpc;
    m   = model_mis();
    pt  = bif.IF_Is_Branch && pht_m[idx_of(bif.IF_PC)] >= 2;
    npc = pt ? bif.IF_Target : bif.IF_PC + 32'd4;
    rpc = m ? (bif.MEM_Taken ? bif.MEM_Target : bif.MEM_PC + 32'd4) : 32'd0;
    chk("m_pred_taken",  {31'd0, bif.Pred_Taken},  {31'd0, pt});
    chk("m_pred_next",   bif.Pred_Next_PC,         npc);
    chk("m_redirect",    {31'd0, bif.PC_Redirect}, {31'd0, m});
    chk("m_redirect_pc", bif.Redirect_PC,          rpc);
    chk("m_flush",       {29'd0, bif.Flush_IF, bif.Flush_ID, bif.Flush_EX}, m ? 32'd7 : 32'd0);
    chk("m_branch_cnt",  {16'd0, bif.Branch_Count},     STATS ? bc_m : 0);
    chk("m_mispred_cnt", {16'd0, bif.Mispredict_Count}, STATS ? mc_m : 0);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic [31:0] pc, input logic br, input logic [31:0] tgt);
    bif.IF_PC        = pc;
    bif.IF_Is_Branch = br;
    bif.IF_Target    = tgt;
  endtask

  task automatic set_mem(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic pr, input logic bub);
    bif.MEM_Valid_Branch = v;
    bif.MEM_PC           = pc;
    bif.MEM_Taken        = tk;
    bif.MEM_Target       = tgt;
    bif.MEM_Pred_Taken   = pr;
    bif.D_Bubble         = bub;
  endtask

  task automatic clr_mem();
    set_mem(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int rc_cycles;
    bit found;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_if(32'd0, 1'b0, 32'd0);
    clr_mem();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset state predicts not-taken
    set_if(32'h40, 1'b1, 32'h400);
    #1;
    chk("t1_pred", {31'd0, bif.Pred_Taken}, 32'd0);
    chk("t1_npc",  bif.Pred_Next_PC, 32'h44);

    // 2: taken mispredict at 0x40 redirects and trains PHT[0] to 10
    set_mem(1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 1'b0);
    #1;
    chk("t2_redirect", {31'd0, bif.PC_Redirect}, 32'd1);
    chk("t2_rpc",      bif.Redirect_PC, 32'h200);
    chk("t2_flush",    {29'd0, bif.Flush_IF, bif.Flush_ID, bif.Flush_EX}, 32'd7);
    cyc();
    clr_mem();
    repeat (3) cyc();
    chk("t2_pred_after", {31'd0, bif.Pred_Taken}, 32'd1);
    chk("t2_npc_after",  bif.Pred_Next_PC, 32'h400);
    // back in IDLE: not-taken mispredict redirects to PC+4
    set_mem(1'b1, 32'h40, 1'b0, 32'h200, 1'b1, 1'b0);
    #1;
    chk("t2_idle_rpc", bif.Redirect_PC, 32'h44);
    cyc();
    clr_mem();
    repeat (3) cyc();

    // 3: recovery masks resolutions, stretched by two bubble cycles
    set_if(32'h108, 1'b1, 32'h500);
    set_mem(1'b1, 32'h104, 1'b1, 32'h300, 1'b0, 1'b0);
    #1;
    chk("t3_redirect", {31'd0, bif.PC_Redirect}, 32'd1);
    cyc();
    set_mem(1'b1, 32'h108, 1'b1, 32'h300, 1'b0, 1'b1);
    rc_cycles = 0;
    found     = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (k == 2) bif.D_Bubble = 1'b0;
      #1;
      if (bif.PC_Redirect) found = 1'b1;
      else begin
        rc_cycles++;
        chk("t3_pred_hold", {31'd0, bif.Pred_Taken}, 32'd0);
        cyc();
      end
    end
    chk("t3_recover_end", {31'd0, found}, 32'd1);
    chk("t3_recover_len", rc_cycles, 32'd5);
    cyc();
    clr_mem();
    repeat (4) cyc();
    chk("t3_one_update", {31'd0, bif.Pred_Taken}, 32'd1);

    // 4: saturation at 0x80 (PHT[0] currently 01)
    set_if(32'h80, 1'b1, 32'h600);
    for (int k = 0; k < 4; k++) begin
      set_mem(1'b1, 32'h80, 1'b1, 32'h600, 1'b1, 1'b0);
      cyc();
    end
    clr_mem();
    #1;
    chk("t4_sat_hi", {31'd0, bif.Pred_Taken}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      set_mem(1'b1, 32'h80, 1'b0, 32'h600, 1'b0, 1'b0);
      cyc();
    end
    set_mem(1'b1, 32'h80, 1'b0, 32'h600, 1'b0, 1'b0);
    #1;
    chk("t4_fifth_noredir", {31'd0, bif.PC_Redirect}, 32'd0);
    cyc();
    clr_mem();
    #1;
    chk("t4_sat_lo", {31'd0, bif.Pred_Taken}, 32'd0);
    set_mem(1'b1, 32'h80, 1'b1, 32'h600, 1'b1, 1'b0);
    cyc();
    clr_mem();
    #1;
    chk("t4_from_00", {31'd0, bif.Pred_Taken}, 32'd0);
    // stalled resolution is deferred, then applied once
    set_mem(1'b1, 32'h80, 1'b1, 32'h600, 1'b1, 1'b1);
    repeat (2) cyc();
    chk("t4_deferred", {31'd0, bif.Pred_Taken}, 32'd0);
    bif.D_Bubble = 1'b0;
    cyc();
    clr_mem();
    #1;
    chk("t4_applied", {31'd0, bif.Pred_Taken}, 32'd1);

    // 5: asynchronous reset in the middle of recovery
    set_mem(1'b1, 32'h80, 1'b0, 32'h600, 1'b1, 1'b0);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_redirect", {31'd0, bif.PC_Redirect}, 32'd0);
    chk("t5_flush",    {29'd0, bif.Flush_IF, bif.Flush_ID, bif.Flush_EX}, 32'd0);
    chk("t5_rpc",      bif.Redirect_PC, 32'd0);
    for (int i = 0; i < 16; i++) begin
      set_if(32'(i * 4), 1'b1, 32'h700);
      #1;
      chk("t5_sweep", {31'd0, bif.Pred_Taken}, 32'd0);
    end
    set_if(32'hFFFF_FFFC, 1'b0, 32'h700);
    #1;
    chk("t5_wrap", bif.Pred_Next_PC, 32'd0);
    cyc();
    rst_n = 1'b1;
    set_if(32'h80, 1'b1, 32'h600);
    set_mem(1'b1, 32'h80, 1'b1, 32'h600, 1'b1, 1'b0);
    cyc();
    clr_mem();
    #1;
    chk("t5_from_01", {31'd0, bif.Pred_Taken}, 32'd1);

    // 6: statistics saturation and mispredict count
    set_mem(1'b1, 32'h84, 1'b1, 32'h700, 1'b1, 1'b0);
    repeat (32'h10002) @(posedge clk);
    #1;
    clr_mem();
    #1;
    chk("t6_branch_cnt", {16'd0, bif.Branch_Count}, STATS ? 32'hFFFF : 32'd0);
    set_mem(1'b1, 32'h84, 1'b0, 32'h700, 1'b1, 1'b0);
    cyc();
    clr_mem();
    #1;
    chk("t6_mispred_cnt", {16'd0, bif.Mispredict_Count}, STATS ? 32'd1 : 32'd0);
    repeat (5) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
